// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download packer: packer states and the FIFO entry layout.
// Entry addresses are carried at a fixed maximum width; the top truncates to its own AW.
package rom_dl_pkg;

  localparam int ENTRY_AW = 32;

  localparam logic [1:0] BE_FULL = 2'b11;
  localparam logic [1:0] BE_EVEN = 2'b10;
  localparam logic [1:0] BE_ODD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_PEND = 2'd2
  } pack_state_e;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [15:0]         data;
    logic [1:0]          be;
  } fifo_entry_t;

endpackage

// File: rtl/rom_download_packer_if.sv
// Word write port towards one SDRAM controller channel (valid/ready handshake).
interface rom_download_packer_if #(
  parameter int AW = 24
) ();
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    wr_be;

  modport master (output wr_valid, output wr_addr, output wr_data, output wr_be, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, input wr_be, output wr_ready);
endinterface

// File: rtl/rom_dl_fifo.sv
// Small register FIFO of packed words; push and pop may coincide even when full.
// The head is read straight from storage registers so the outputs never see ioctl_* combinationally.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_empty,
  output logic        o_full,
  output logic        o_overflow_evt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t     r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_empty        = (r_count == '0);
  assign o_full         = (r_count == (PW+1)'(DEPTH));
  assign w_pop          = i_pop & ~o_empty;
  // When full, the slot being written is the one being popped this same cycle.
  assign w_push         = i_push & (~o_full | w_pop);
  assign o_overflow_evt = i_push & o_full & ~w_pop;
  assign o_head         = r_mem[r_rd_ptr];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rom_download_packer.sv
// Packs the data_io byte stream into big-endian 16-bit words with byte enables and
// queues them for an SDRAM write port; flushes a half word when the download window closes.
module rom_download_packer
  import rom_dl_pkg::*;
#(
  parameter int          AW    = 24,
  parameter int          DEPTH = 4,
  parameter int unsigned BASE  = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   rom_download,
  input  logic                   ioctl_wr,
  input  logic [AW:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  rom_download_packer_if.master  wr,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);
  localparam logic [AW-1:0] BASE_W = AW'(BASE);

  pack_state_e   r_state;
  logic          r_dl;
  logic [AW-1:0] r_hold_addr;
  logic [7:0]    r_hold_byte;
  logic          r_armed;
  logic          r_done;
  logic          r_overflow;

  logic          w_rise, w_fall, w_wr, w_odd, w_same_word, w_drained;
  logic [AW-1:0] w_byte_waddr;
  logic          w_push;
  logic [AW-1:0] w_push_addr;
  logic [AW-1:0] w_out_addr;
  logic [7:0]    w_push_hi, w_push_lo;
  logic [1:0]    w_push_be;
  fifo_entry_t   w_entry, w_head;
  logic          w_empty, w_full, w_ovf_evt, w_pop;
  logic          w_unused_addr;

  assign w_rise       = rom_download & ~r_dl;
  assign w_fall       = r_dl & ~rom_download;
  assign w_wr         = ioctl_wr & rom_download;
  assign w_odd        = ioctl_addr[0];
  assign w_byte_waddr = ioctl_addr[AW:1];
  assign w_same_word  = (w_byte_waddr == r_hold_addr);
  assign w_drained    = ~rom_download & (r_state == ST_IDLE) & w_empty;

  // At most one push per cycle: writes are spaced, and PEND only follows a HALF push.
  always_comb begin
    w_push      = 1'b0;
    w_push_addr = r_hold_addr;
    w_push_hi   = r_hold_byte;
    w_push_lo   = 8'h00;
    w_push_be   = BE_EVEN;
    case (r_state)
      ST_IDLE: begin
        if (w_wr && w_odd) begin
          w_push      = 1'b1;
          w_push_addr = w_byte_waddr;
          w_push_hi   = 8'h00;
          w_push_lo   = ioctl_dout;
          w_push_be   = BE_ODD;
        end
      end
      ST_HALF: begin
        if (w_wr && w_odd && w_same_word) begin
          w_push    = 1'b1;
          w_push_lo = ioctl_dout;
          w_push_be = BE_FULL;
        end else if (w_wr || w_fall) begin
          w_push = 1'b1;
        end
      end
      ST_PEND: begin
        w_push    = 1'b1;
        w_push_hi = 8'h00;
        w_push_lo = r_hold_byte;
        w_push_be = BE_ODD;
      end
      default: ;
    endcase
  end

  assign w_out_addr   = w_push_addr + BASE_W;
  assign w_entry.addr = ENTRY_AW'(w_out_addr);
  assign w_entry.data = {w_push_hi, w_push_lo};
  assign w_entry.be   = w_push_be;

  rom_dl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .i_push         (w_push),
    .i_entry        (w_entry),
    .i_pop          (w_pop),
    .o_head         (w_head),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .o_overflow_evt (w_ovf_evt)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dl        <= 1'b0;
      r_hold_addr <= '0;
      r_hold_byte <= '0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_dl <= rom_download;
      case (r_state)
        ST_IDLE: begin
          if (w_wr && !w_odd) begin
            r_hold_addr <= w_byte_waddr;
            r_hold_byte <= ioctl_dout;
            r_state     <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (w_wr) begin
            r_hold_addr <= w_byte_waddr;
            r_hold_byte <= ioctl_dout;
            if (!w_odd)          r_state <= ST_HALF;
            else if (w_same_word) r_state <= ST_IDLE;
            else                 r_state <= ST_PEND;
          end else if (w_fall) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      r_done <= r_armed & w_drained;
      if (w_rise)                    r_armed <= 1'b0;
      else if (w_fall)               r_armed <= 1'b1;
      else if (r_armed && w_drained) r_armed <= 1'b0;

      if (w_ovf_evt)   r_overflow <= 1'b1;
      else if (w_rise) r_overflow <= 1'b0;
    end
  end

  assign w_pop         = wr.wr_valid & wr.wr_ready;
  assign wr.wr_valid   = ~w_empty;
  assign wr.wr_addr    = w_head.addr[AW-1:0];
  assign wr.wr_data    = w_head.data;
  assign wr.wr_be      = w_head.be;
  assign w_unused_addr = ^(w_head.addr >> AW) ^ w_full;

  assign busy     = (r_state != ST_IDLE) | ~w_empty;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_rom_download_packer.sv
// Directed bench for rom_download_packer: two instances (BASE=0 and BASE=0x100000) share the byte stream.
`timescale 1ns/1ps
module tb_rom_download_packer;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        rom_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

  rom_download_packer_if #(.AW(24)) bus_a ();
  rom_download_packer_if #(.AW(24)) bus_b ();

  rom_download_packer #(.AW(24), .DEPTH(4), .BASE(0)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .rom_download(rom_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .wr(bus_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a));

  rom_download_packer #(.AW(24), .DEPTH(4), .BASE(32'h100000)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .rom_download(rom_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .wr(bus_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b));

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  logic [41:0] cap_a[$];
  logic [41:0] cap_b[$];
  int done_cnt_a = 0;

  // Accepted words are logged at the negedge preceding the popping posedge.
  always @(negedge clk_sys) begin
    if (bus_a.wr_valid && bus_a.wr_ready) cap_a.push_back({bus_a.wr_addr, bus_a.wr_data, bus_a.wr_be});
    if (bus_b.wr_valid && bus_b.wr_ready) cap_b.push_back({bus_b.wr_addr, bus_b.wr_data, bus_b.wr_be});
    if (done_a) done_cnt_a++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  function automatic logic [41:0] head_a();
    return {bus_a.wr_addr, bus_a.wr_data, bus_a.wr_be};
  endfunction

  function automatic logic [41:0] cap_at_a(input int idx);
    if (idx < cap_a.size()) return cap_a[idx];
    return 'x;
  endfunction

  task automatic test_reset();
    logic [45:0] got;
    reset = 1'b1;
    bus_b.wr_ready = 1'b1;
    bus_a.wr_ready = 1'b1;
    tick(); tick();
    got = {bus_a.wr_valid, busy_a, done_a, ovf_a, head_a()};
    checks++;
    if (got !== 46'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", got); end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus_a.wr_valid, busy_a} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got=%b exp=00", {bus_a.wr_valid, busy_a}); end
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    int base = cap_a.size();
    int dbase;
    rom_download = 1'b1;
    tick(); tick();
    wr_byte(25'd0, 8'h12);
    checks++;
    if ({busy_a, bus_a.wr_valid} !== 2'b10) begin failures++; $display("FAIL half_busy got=%b exp=10", {busy_a, bus_a.wr_valid}); end
    ioctl_addr = 25'd1; ioctl_dout = 8'h34; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if ({bus_a.wr_valid, head_a()} !== {1'b1, 24'h0, 16'h1234, 2'b11}) begin
      failures++; $display("FAIL word_head got=%h exp=%h", {bus_a.wr_valid, head_a()}, {1'b1, 24'h0, 16'h1234, 2'b11});
    end
    tick(); tick(); tick();
    checks++;
    if (cap_a.size() - base !== 1 || cap_at_a(base) !== {24'h0, 16'h1234, 2'b11}) begin
      failures++; $display("FAIL word_capture got_n=%0d got=%h exp=%h", cap_a.size() - base, cap_at_a(base), {24'h0, 16'h1234, 2'b11});
    end
    dbase = done_cnt_a;
    rom_download = 1'b0;
    tick();
    checks++;
    if (done_a !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done_a); end
    tick();
    checks++;
    if (done_a !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", done_a); end
    tick(); tick();
    checks++;
    if (done_cnt_a - dbase !== 1) begin failures++; $display("FAIL done_once got=%0d exp=1", done_cnt_a - dbase); end
    $display("test_full_word done");
  endtask

  task automatic test_flush();
    int base;
    rom_download = 1'b1;
    tick();
    base = cap_a.size();
    wr_byte(25'd4, 8'hAB);
    rom_download = 1'b0;
    tick();
    checks++;
    if ({bus_a.wr_valid, busy_a, head_a()} !== {2'b11, 24'h2, 16'hAB00, 2'b10}) begin
      failures++; $display("FAIL flush_head got=%h exp=%h", {bus_a.wr_valid, busy_a, head_a()}, {2'b11, 24'h2, 16'hAB00, 2'b10});
    end
    tick();
    checks++;
    if ({bus_a.wr_valid, busy_a, done_a} !== 3'b000) begin failures++; $display("FAIL flush_busy_drop got=%b exp=000", {bus_a.wr_valid, busy_a, done_a}); end
    tick();
    checks++;
    if (done_a !== 1'b1) begin failures++; $display("FAIL flush_done got=%b exp=1", done_a); end
    checks++;
    if (cap_a.size() - base !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", cap_a.size() - base); end
    tick();
    $display("test_flush done");
  endtask

  task automatic test_pend();
    int base;
    rom_download = 1'b1;
    tick();
    base = cap_a.size();
    wr_byte(25'd2, 8'h11);
    ioctl_addr = 25'd7; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if (head_a() !== {24'h1, 16'h1100, 2'b10}) begin failures++; $display("FAIL pend_first got=%h exp=%h", head_a(), {24'h1, 16'h1100, 2'b10}); end
    tick();
    checks++;
    if ({bus_a.wr_valid, head_a()} !== {1'b1, 24'h3, 16'h0022, 2'b01}) begin
      failures++; $display("FAIL pend_second got=%h exp=%h", {bus_a.wr_valid, head_a()}, {1'b1, 24'h3, 16'h0022, 2'b01});
    end
    tick(); tick();
    checks++;
    if (cap_a.size() - base !== 2 || cap_at_a(base + 1) !== {24'h3, 16'h0022, 2'b01}) begin
      failures++; $display("FAIL pend_capture got_n=%0d got=%h", cap_a.size() - base, cap_at_a(base + 1));
    end
    $display("test_pend done");
  endtask

  task automatic test_even_even();
    int base = cap_a.size();
    wr_byte(25'd8, 8'h55);
    wr_byte(25'd10, 8'h66);
    wr_byte(25'd11, 8'h77);
    wr_byte(25'd13, 8'h99);
    tick(); tick();
    checks++;
    if (cap_at_a(base) !== {24'h4, 16'h5500, 2'b10}) begin failures++; $display("FAIL even_partial got=%h exp=%h", cap_at_a(base), {24'h4, 16'h5500, 2'b10}); end
    checks++;
    if (cap_at_a(base + 1) !== {24'h5, 16'h6677, 2'b11}) begin failures++; $display("FAIL even_full got=%h exp=%h", cap_at_a(base + 1), {24'h5, 16'h6677, 2'b11}); end
    checks++;
    if (cap_at_a(base + 2) !== {24'h6, 16'h0099, 2'b01}) begin failures++; $display("FAIL idle_odd got=%h exp=%h", cap_at_a(base + 2), {24'h6, 16'h0099, 2'b01}); end
    rom_download = 1'b0;
    tick(); tick(); tick(); tick();
    $display("test_even_even done");
  endtask

  task automatic test_overflow();
    int base;
    bus_a.wr_ready = 1'b0;
    rom_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      wr_byte(25'(2 * i), 8'(8'h10 + i));
      wr_byte(25'(2 * i + 1), 8'(8'h80 + i));
    end
    checks++;
    if ({ovf_a, bus_a.wr_valid, head_a()} !== {2'b11, 24'h0, 16'h1080, 2'b11}) begin
      failures++; $display("FAIL ovf_hold got=%h exp=%h", {ovf_a, bus_a.wr_valid, head_a()}, {2'b11, 24'h0, 16'h1080, 2'b11});
    end
    base = cap_a.size();
    bus_a.wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (cap_a.size() - base !== 4 || bus_a.wr_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_drain_count got=%0d valid=%b exp=4 valid=0", cap_a.size() - base, bus_a.wr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      logic [41:0] exp;
      exp = {24'(i), 8'(8'h10 + i), 8'(8'h80 + i), 2'b11};
      checks++;
      if (cap_at_a(base + i) !== exp) begin failures++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, cap_at_a(base + i), exp); end
    end
    rom_download = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (ovf_a !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf_a); end
    rom_download = 1'b1;
    tick();
    checks++;
    if (ovf_a !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_a); end
    $display("test_overflow done");
  endtask

  task automatic test_wrap();
    int base_a = cap_a.size();
    int base_b = cap_b.size();
    logic [41:0] got_b;
    wr_byte(25'h1FFFFFE, 8'h5A);
    wr_byte(25'h1FFFFFF, 8'hA5);
    tick(); tick();
    checks++;
    if (cap_at_a(base_a) !== {24'hFFFFFF, 16'h5AA5, 2'b11}) begin failures++; $display("FAIL wrap_base0 got=%h exp=%h", cap_at_a(base_a), {24'hFFFFFF, 16'h5AA5, 2'b11}); end
    got_b = (base_b < cap_b.size()) ? cap_b[base_b] : 'x;
    checks++;
    if (got_b !== {24'h0FFFFF, 16'h5AA5, 2'b11}) begin failures++; $display("FAIL wrap_base got=%h exp=%h", got_b, {24'h0FFFFF, 16'h5AA5, 2'b11}); end
    rom_download = 1'b0;
    tick(); tick(); tick(); tick();
    base_a = cap_a.size();
    wr_byte(25'd0, 8'hEE);
    wr_byte(25'd1, 8'hEF);
    checks++;
    if ({busy_a, bus_a.wr_valid} !== 2'b00 || cap_a.size() != base_a) begin
      failures++; $display("FAIL ignore_wr got=%b n=%0d exp=00 n=0", {busy_a, bus_a.wr_valid}, cap_a.size() - base_a);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    int base;
    int dbase;
    logic [45:0] got;
    bus_a.wr_ready = 1'b0;
    rom_download = 1'b1;
    tick();
    wr_byte(25'd0, 8'h01); wr_byte(25'd1, 8'h02);
    wr_byte(25'd2, 8'h03); wr_byte(25'd3, 8'h04);
    wr_byte(25'd4, 8'h05);
    checks++;
    if ({bus_a.wr_valid, busy_a} !== 2'b11) begin failures++; $display("FAIL mid_prefill got=%b exp=11", {bus_a.wr_valid, busy_a}); end
    @(posedge clk_sys);
    #3;
    reset = 1'b1;
    rom_download = 1'b0;
    #1;
    got = {bus_a.wr_valid, busy_a, done_a, ovf_a, head_a()};
    checks++;
    if (got !== 46'd0) begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0", got); end
    tick(); tick();
    reset = 1'b0;
    base = cap_a.size();
    dbase = done_cnt_a;
    bus_a.wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (cap_a.size() - base !== 0 || bus_a.wr_valid !== 1'b0) begin
      failures++; $display("FAIL mid_no_stale got=%0d valid=%b exp=0", cap_a.size() - base, bus_a.wr_valid);
    end
    checks++;
    if (done_cnt_a - dbase !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt_a - dbase); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_pend();
    test_even_even();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
